// File: rtl/pe_vec_feeder_pkg.sv
// Shared constants for the PE vector feeder: default widths, kernel size and FSM encoding.
package pe_vec_feeder_pkg;

  localparam int IFMAP_WID_DEF  = 8;
  localparam int WEIGHT_WID_DEF = 8;
  localparam int PSUM_WID_DEF   = 20;
  localparam int PSUM_LAT_DEF   = 1;
  localparam int KSIZE          = 3;
  localparam int SEL_W          = $clog2(KSIZE);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD_W = 3'd1;
  localparam state_t ST_FILL   = 3'd2;
  localparam state_t ST_CLEAR  = 3'd3;
  localparam state_t ST_MAC    = 3'd4;
  localparam state_t ST_WAIT   = 3'd5;
  localparam state_t ST_OUT    = 3'd6;

  // Window occupancy only needs to know "full", so it saturates at three columns.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/pe_vec_window.sv
// Three-column ifmap shift window; column 0 is the oldest column, column 2 the newest.
module pe_vec_window
  import pe_vec_feeder_pkg::*;
#(
  parameter int COL_WID = 24
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               shift_i,
  input  logic [COL_WID-1:0] col_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [COL_WID-1:0] col_o
);

  logic [COL_WID-1:0] col0_q, col1_q, col2_q;

  // Shift register: a new column enters at the newest slot, the oldest falls out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col0_q <= {COL_WID{1'b0}};
      col1_q <= {COL_WID{1'b0}};
      col2_q <= {COL_WID{1'b0}};
    end else if (shift_i) begin
      col0_q <= col1_q;
      col1_q <= col2_q;
      col2_q <= col_i;
    end
  end

  // Column select for the MAC step.
  always_comb begin
    case (sel_i)
      2'd0:    col_o = col0_q;
      2'd1:    col_o = col1_q;
      2'd2:    col_o = col2_q;
      default: col_o = {COL_WID{1'b0}};
    endcase
  end

endmodule

// File: rtl/pe_vec_feeder.sv
// Feeds a 3-PE vector with kernel/ifmap columns and collects one psum per window position.
// Optional build macro PE_VEC_FEEDER_RELU_EN clamps negative captured psums to zero.
module pe_vec_feeder
  import pe_vec_feeder_pkg::*;
#(
  parameter int IFMAP_WID  = IFMAP_WID_DEF,
  parameter int WEIGHT_WID = WEIGHT_WID_DEF,
  parameter int PSUM_WID   = PSUM_WID_DEF,
  parameter int PSUM_LAT   = PSUM_LAT_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [7:0]                   cfg_row_len_i,
  input  logic                         cfg_load_w_i,
  input  logic                         w_valid_i,
  output logic                         w_ready_o,
  input  logic [KSIZE*WEIGHT_WID-1:0]  w_data_i,
  input  logic                         act_valid_i,
  output logic                         act_ready_o,
  input  logic [KSIZE*IFMAP_WID-1:0]   act_data_i,
  output logic                         pe_ifmap_wen_o,
  output logic                         pe_weight_wen_o,
  output logic                         pe_reg_clear_o,
  output logic [IFMAP_WID-1:0]         pe1_ifmap_o,
  output logic [IFMAP_WID-1:0]         pe2_ifmap_o,
  output logic [IFMAP_WID-1:0]         pe3_ifmap_o,
  output logic [WEIGHT_WID-1:0]        pe1_weight_o,
  output logic [WEIGHT_WID-1:0]        pe2_weight_o,
  output logic [WEIGHT_WID-1:0]        pe3_weight_o,
  input  logic signed [PSUM_WID-1:0]   pe_psum_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic signed [PSUM_WID-1:0]   out_data_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int ACT_W = KSIZE * IFMAP_WID;
  localparam int KER_W = KSIZE * WEIGHT_WID;

  state_t               state_q, state_d;
  logic [7:0]           row_len_q, row_len_d;
  logic [SEL_W-1:0]     wcnt_q, wcnt_d;
  logic [1:0]           fill_q, fill_d;
  logic [SEL_W-1:0]     step_q, step_d;
  logic [7:0]           lat_q, lat_d;
  logic [7:0]           outcnt_q, outcnt_d;
  logic [KER_W-1:0]     kern0_q, kern1_q, kern2_q;
  logic [KER_W-1:0]     kcol_s;
  logic [ACT_W-1:0]     win_col_s;
  logic                 shift_s, kload_s, cap_s, done_d;
  logic signed [PSUM_WID-1:0] psum_cap_s;

  logic                 w_ready_q, act_ready_q, clear_q, wen_q, out_valid_q, busy_q, done_q;
  logic [ACT_W-1:0]     pe_if_q;
  logic [KER_W-1:0]     pe_w_q;
  logic signed [PSUM_WID-1:0] out_data_q;

  pe_vec_window #(.COL_WID(ACT_W)) u_window (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .shift_i (shift_s),
    .col_i   (act_data_i),
    .sel_i   (step_d),
    .col_o   (win_col_s)
  );

`ifdef PE_VEC_FEEDER_RELU_EN
  assign psum_cap_s = pe_psum_i[PSUM_WID-1] ? {PSUM_WID{1'b0}} : pe_psum_i;
`else
  assign psum_cap_s = pe_psum_i;
`endif

  // Job sequencing: next state, counters and the strobes that move data.
  always_comb begin
    state_d   = state_q;
    row_len_d = row_len_q;
    wcnt_d    = wcnt_q;
    fill_d    = fill_q;
    step_d    = step_q;
    lat_d     = lat_q;
    outcnt_d  = outcnt_q;
    done_d    = 1'b0;
    shift_s   = 1'b0;
    kload_s   = 1'b0;
    cap_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          row_len_d = cfg_row_len_i;
          wcnt_d    = {SEL_W{1'b0}};
          fill_d    = 2'd0;
          outcnt_d  = 8'd0;
          if (cfg_row_len_i == 8'd0) begin
            done_d = 1'b1;
          end else if (cfg_load_w_i) begin
            state_d = ST_LOAD_W;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        if (w_valid_i && w_ready_q) begin
          kload_s = 1'b1;
          wcnt_d  = wcnt_q + 2'd1;
          if (wcnt_q == 2'd2) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_LOAD_W;
          end
        end else begin
          state_d = ST_LOAD_W;
        end
      end
      ST_FILL: begin
        if (act_valid_i && act_ready_q) begin
          shift_s = 1'b1;
          fill_d  = sat_inc2(fill_q);
          // Short rows never fill the window: swallow the columns and finish.
          if ((row_len_q < 8'd3) && ((8'(fill_q) + 8'd1) == row_len_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (fill_q >= 2'd2) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_CLEAR: begin
        state_d = ST_MAC;
        step_d  = {SEL_W{1'b0}};
      end
      ST_MAC: begin
        if (step_q == 2'd2) begin
          state_d = ST_WAIT;
          lat_d   = 8'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      ST_WAIT: begin
        if (lat_q == 8'(PSUM_LAT)) begin
          cap_s   = 1'b1;
          state_d = ST_OUT;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      ST_OUT: begin
        if (out_ready_i && out_valid_q) begin
          outcnt_d = outcnt_q + 8'd1;
          if ((outcnt_q + 8'd1) == (row_len_q - 8'd2)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Kernel column feeding the PEs in the upcoming MAC step.
  always_comb begin
    case (step_d)
      2'd0:    kcol_s = kern0_q;
      2'd1:    kcol_s = kern1_q;
      2'd2:    kcol_s = kern2_q;
      default: kcol_s = kern0_q;
    endcase
  end

  // FSM state and job counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      row_len_q <= 8'd0;
      wcnt_q    <= {SEL_W{1'b0}};
      fill_q    <= 2'd0;
      step_q    <= {SEL_W{1'b0}};
      lat_q     <= 8'd0;
      outcnt_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      row_len_q <= row_len_d;
      wcnt_q    <= wcnt_d;
      fill_q    <= fill_d;
      step_q    <= step_d;
      lat_q     <= lat_d;
      outcnt_q  <= outcnt_d;
    end
  end

  // Kernel store, kept across jobs until the next load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kern0_q <= {KER_W{1'b0}};
      kern1_q <= {KER_W{1'b0}};
      kern2_q <= {KER_W{1'b0}};
    end else if (kload_s) begin
      case (wcnt_q)
        2'd0:    kern0_q <= w_data_i;
        2'd1:    kern1_q <= w_data_i;
        2'd2:    kern2_q <= w_data_i;
        default: kern0_q <= kern0_q;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_ready_q   <= 1'b0;
      act_ready_q <= 1'b0;
      clear_q     <= 1'b0;
      wen_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pe_if_q     <= {ACT_W{1'b0}};
      pe_w_q      <= {KER_W{1'b0}};
      out_data_q  <= {PSUM_WID{1'b0}};
    end else begin
      w_ready_q   <= (state_d == ST_LOAD_W);
      act_ready_q <= (state_d == ST_FILL);
      clear_q     <= (state_d == ST_CLEAR);
      wen_q       <= (state_d == ST_MAC);
      out_valid_q <= (state_d == ST_OUT);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
      if (state_d == ST_MAC) begin
        pe_if_q <= win_col_s;
        pe_w_q  <= kcol_s;
      end
      if (cap_s) begin
        out_data_q <= psum_cap_s;
      end
    end
  end

  assign w_ready_o       = w_ready_q;
  assign act_ready_o     = act_ready_q;
  assign pe_reg_clear_o  = clear_q;
  assign pe_ifmap_wen_o  = wen_q;
  assign pe_weight_wen_o = wen_q;
  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pe1_ifmap_o     = pe_if_q[IFMAP_WID-1:0];
  assign pe2_ifmap_o     = pe_if_q[2*IFMAP_WID-1:IFMAP_WID];
  assign pe3_ifmap_o     = pe_if_q[3*IFMAP_WID-1:2*IFMAP_WID];
  assign pe1_weight_o    = pe_w_q[WEIGHT_WID-1:0];
  assign pe2_weight_o    = pe_w_q[2*WEIGHT_WID-1:WEIGHT_WID];
  assign pe3_weight_o    = pe_w_q[3*WEIGHT_WID-1:2*WEIGHT_WID];

endmodule

// File: tb/tb_pe_vec_feeder.sv
// Scoreboard bench for pe_vec_feeder with a behavioural 3-PE accumulator (PSUM_LAT = 1).
module tb_pe_vec_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] cfg_row_len = 8'd0;
  logic cfg_load_w = 1'b0;
  logic w_valid = 1'b0;
  logic w_ready;
  logic [23:0] w_data = 24'd0;
  logic act_valid = 1'b0;
  logic act_ready;
  logic [23:0] act_data = 24'd0;
  logic pe_ifmap_wen, pe_weight_wen, pe_reg_clear;
  logic [7:0] pe1_ifmap, pe2_ifmap, pe3_ifmap, pe1_weight, pe2_weight, pe3_weight;
  logic signed [19:0] pe_psum;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [19:0] out_data;
  logic busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, w_seen = 0, ov_seen = 0, both_rdy = 0;
  int job_len = 0, cols = 0, wi = 0;
  int kern[3][3];
  int wcol[3][3];
  int exp_q[$];

  always #5 clk = ~clk;

  pe_vec_feeder dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cfg_row_len_i(cfg_row_len),
    .cfg_load_w_i(cfg_load_w), .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
    .act_valid_i(act_valid), .act_ready_o(act_ready), .act_data_i(act_data),
    .pe_ifmap_wen_o(pe_ifmap_wen), .pe_weight_wen_o(pe_weight_wen), .pe_reg_clear_o(pe_reg_clear),
    .pe1_ifmap_o(pe1_ifmap), .pe2_ifmap_o(pe2_ifmap), .pe3_ifmap_o(pe3_ifmap),
    .pe1_weight_o(pe1_weight), .pe2_weight_o(pe2_weight), .pe3_weight_o(pe3_weight),
    .pe_psum_i(pe_psum), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy), .done_o(done)
  );

  function automatic logic signed [19:0] sx(input logic [7:0] v);
    return 20'($signed(v));
  endfunction

  // PE vector model: clearable accumulator plus one psum pipeline stage.
  logic signed [19:0] acc, psum_pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 20'sd0;
      psum_pipe <= 20'sd0;
    end else begin
      if (pe_reg_clear) acc <= 20'sd0;
      else if (pe_ifmap_wen && pe_weight_wen)
        acc <= acc + sx(pe1_ifmap) * sx(pe1_weight) + sx(pe2_ifmap) * sx(pe2_weight)
                   + sx(pe3_ifmap) * sx(pe3_weight);
      psum_pipe <= acc;
    end
  end
  assign pe_psum = psum_pipe;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor and protocol counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (w_ready) w_seen++;
      if (out_valid) ov_seen++;
      if (w_ready && act_ready) both_rdy++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic push_col(input int v0, input int v1, input int v2);
    int s;
    for (int n = 0; n < 3; n++) begin
      wcol[0][n] = wcol[1][n];
      wcol[1][n] = wcol[2][n];
    end
    wcol[2][0] = v0; wcol[2][1] = v1; wcol[2][2] = v2;
    cols++;
    if (job_len >= 3 && cols >= 3) begin
      s = 0;
      for (int k = 0; k < 3; k++)
        for (int n = 0; n < 3; n++) s += kern[k][n] * wcol[k][n];
`ifdef PE_VEC_FEEDER_RELU_EN
      if (s < 0) s = 0;
`endif
      exp_q.push_back(s);
    end
  endtask

  task automatic start_job(input int len, input bit lw);
    @(negedge clk);
    cfg_row_len = 8'(len); cfg_load_w = lw; start = 1'b1;
    job_len = len; cols = 0; wi = 0; w_seen = 0; ov_seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_w(input int v0, input int v1, input int v2);
    bit ok = 1'b0;
    w_data = {8'(v2), 8'(v1), 8'(v0)};
    w_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (w_ready) begin @(posedge clk); #1; ok = 1'b1; end
    end
    w_valid = 1'b0;
    check("w_accept", ok, 1);
    kern[wi][0] = v0; kern[wi][1] = v1; kern[wi][2] = v2;
    wi++;
  endtask

  task automatic send_act(input int v0, input int v1, input int v2);
    bit ok = 1'b0;
    act_data = {8'(v2), 8'(v1), 8'(v0)};
    act_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (act_ready) begin @(posedge clk); #1; ok = 1'b1; end
    end
    act_valid = 1'b0;
    check("act_accept", ok, 1);
    if (ok) push_col(v0, v1, v2);
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check(tag, done_cnt - d0, 1);
  endtask

  initial begin
    int d0, bad;
    logic signed [19:0] held;
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 3; n++) begin kern[k][n] = 0; wcol[k][n] = 0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_act_ready", act_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_clear", pe_reg_clear, 0);
    @(negedge clk) rst_n = 1'b1;

    // Row of 5 with kernel load: columns 1..5.
    start_job(5, 1'b1);
    check("busy_after_start", busy, 1);
    check("w_ready_load", w_ready, 1);
    for (int k = 0; k < 3; k++) send_w(1, 1, 1);
    for (int c = 0; c < 5; c++) send_act(c + 1, c + 1, c + 1);
    wait_done("done_row5");
    check("busy_idle", busy, 0);

    // Reuse kernel, row of 3 of all-2 columns.
    start_job(3, 1'b0);
    for (int c = 0; c < 3; c++) send_act(2, 2, 2);
    wait_done("done_row3");
    check("no_w_ready_reuse", w_seen, 0);

    // Output back-pressure.
    out_ready = 1'b0;
    start_job(3, 1'b0);
    for (int c = 0; c < 3; c++) send_act(c + 1, c + 1, c + 1);
    for (int i = 0; i < 50 && !out_valid; i++) begin @(posedge clk); #1; end
    check("ov_rise", out_valid, 1);
    held = out_data;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== held || act_ready) bad++;
    end
    check("hold_stable", bad, 0);
    out_ready = 1'b1;
    wait_done("done_bp");

    // Short row: two beats, no output.
    start_job(2, 1'b0);
    send_act(7, 7, 7);
    send_act(8, 8, 8);
    check("done_short", done, 1);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("short_no_out", ov_seen, 0);

    // Empty row.
    start_job(0, 1'b0);
    check("done_empty", done, 1);
    check("busy_empty", busy, 0);

    // Negative kernel.
    start_job(3, 1'b1);
    for (int k = 0; k < 3; k++) send_w(-1, -1, -1);
    for (int c = 0; c < 3; c++) send_act(1, 1, 1);
    wait_done("done_neg");

    // Reset during MAC step 1.
    start_job(3, 1'b0);
    for (int c = 0; c < 3; c++) send_act(1, 1, 1);
    for (int i = 0; i < 50 && !pe_ifmap_wen; i++) begin @(posedge clk); #1; end
    check("mac_seen", pe_ifmap_wen, 1);
    @(posedge clk); #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_wen", pe_ifmap_wen, 0);
    check("mrst_ifmap", pe1_ifmap, 0);
    check("mrst_weight", pe1_weight, 0);
    check("mrst_done", done, 0);
    exp_q.delete();
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 3; n++) begin kern[k][n] = 0; wcol[k][n] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    check("mrst_no_done", done_cnt - d0, 0);

    // Kernel was cleared by reset, then a fresh kernel with distinct lanes.
    start_job(3, 1'b0);
    for (int c = 0; c < 3; c++) send_act(5, 5, 5);
    wait_done("done_after_rst");
    start_job(3, 1'b1);
    for (int k = 0; k < 3; k++) send_w(1, 2, 3);
    for (int c = 0; c < 3; c++) send_act(1, 2, 3);
    wait_done("done_lanes");

    check("sb_empty", exp_q.size(), 0);
    check("never_both_ready", both_rdy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_vec_feeder.md
PE_VEC_FEEDER -- requirements
Module: pe_vec_feeder

Interface
REQ-001 Parameter IFMAP_WID, default 8, ifmap element width.
REQ-002 Parameter WEIGHT_WID, default 8, weight element width.
REQ-003 Parameter PSUM_WID, default 20, PE_vec psum width.
REQ-004 Parameter PSUM_LAT, default 1, cycles after the last MAC step before pe_psum is valid.
REQ-005 Ports: clk in 1 clock; rst in 1 reset, asynchronous, active-low.
REQ-006 Ports: start in 1 job start pulse; cfg_row_len in 8 columns in row; cfg_load_w in 1 load new kernel this job.
REQ-007 Ports: w_valid in 1, w_ready out 1, w_data in 3*WEIGHT_WID: one kernel column, lane n for PE n.
REQ-008 Ports: act_valid in 1, act_ready out 1, act_data in 3*IFMAP_WID: one ifmap column, lane n for PE n.
REQ-009 Ports: pe_ifmap_wen, pe_weight_wen, pe_reg_clear out 1 each; pe1/2/3_ifmap out IFMAP_WID; pe1/2/3_weight out WEIGHT_WID; pe_psum in PSUM_WID signed.
REQ-010 Ports: out_valid out 1, out_ready in 1, out_data out PSUM_WID signed; busy out 1; done out 1 single-cycle pulse.

Function
REQ-011 States IDLE, LOAD_W, FILL, CLEAR, MAC, WAIT, OUT.
REQ-012 IDLE: start latches cfg_row_len, cfg_load_w; go LOAD_W if cfg_load_w else FILL; start ignored while busy.
REQ-013 LOAD_W: w_ready=1; 3 accepted beats fill kernel columns 0..2 in order; then FILL; kernel retained across jobs.
REQ-014 FILL: act_ready=1; accepted column shifts into 3-column window (oldest out); go CLEAR when window holds 3 columns of this job.
REQ-015 CLEAR: pe_reg_clear=1 for exactly one cycle; then MAC.
REQ-016 MAC: 3 cycles, step k=0..2; pe_ifmap_wen=pe_weight_wen=1; peN_ifmap=window col k lane N; peN_weight=kernel col k lane N.
REQ-017 WAIT: PSUM_LAT cycles (0 allowed: capture in the cycle after MAC step 2); capture pe_psum into out_data register; go OUT.
REQ-018 OUT: out_valid=1, out_data stable until out_ready; on handshake, if outputs emitted == cfg_row_len-2 pulse done and go IDLE, else go FILL for one more column.
REQ-019 cfg_row_len<3: accept cfg_row_len columns, emit no output, pulse done, return IDLE; cfg_row_len=0 pulses done in the cycle after start.
REQ-020 All PE control outputs 0 outside CLEAR/MAC; PE data outputs hold last value.
REQ-021 busy=1 in every state except IDLE.
REQ-022 w_ready only in LOAD_W, act_ready only in FILL; never both.

Reset
REQ-023 rst low: state IDLE; all counters, window, kernel, out_data cleared to 0; all outputs 0.
REQ-024 Reset mid-job aborts immediately; no done pulse; in-flight beats dropped.

Configuration
REQ-025 PE_VEC_FEEDER_RELU_EN defined: captured psum<0 stored as 0. Undefined: psum passed unmodified.

Structure
REQ-026 Shared package: width constants IFMAP_WID/WEIGHT_WID/PSUM_WID defaults, state enum, kernel size 3.
REQ-027 Sub-module pe_vec_window: 3-column shift window with shift enable and column select; kernel store is inline.

Verification
REQ-028 cfg_load_w=1, kernel all 1, row_len=5, column c lanes all c+1 -> outputs 18, 27, 36, then done once.
REQ-029 cfg_load_w=0 after REQ-028, row_len=3, columns all 2 -> single output 18; no w_ready asserted.
REQ-030 out_ready held 0 for 10 cycles -> out_valid and out_data stable; act_ready 0 throughout.
REQ-031 row_len=2 -> two act beats accepted, no out_valid, done one cycle after second beat.
REQ-032 RELU_EN, kernel all -1, columns all 1 -> out_data 0; without macro -> -9.
REQ-033 rst low during MAC step 1 -> all outputs 0 immediately, IDLE, no done; next job completes normally.
